// File: rtl/beam_pkg.sv
// Shared defaults and types for the beamformer steering delay bank.
package beam_pkg;
  localparam int N_CH_DEF  = 8;
  localparam int W_DEF     = 19;
  localparam int DEPTH_DEF = 32;
  localparam int N_DIR_DEF = 32;

  typedef logic [$clog2(DEPTH_DEF)-1:0] delay_t;

  typedef enum logic [1:0] {
    RL_IDLE,
    RL_LOAD,
    RL_PEND
  } reload_e;
endpackage

// File: rtl/delay_ring.sv
// One channel's sample history: circular buffer with a registered tap at wp - dly.
module delay_ring import beam_pkg::*; #(
  parameter  int W     = W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [AW-1:0] wp_i,
  input  logic          we_i,
  input  logic [W-1:0]  din_i,
  input  logic [AW-1:0] dly_i,
  output logic [W-1:0]  dout_o
);
  logic [DEPTH-1:0][W-1:0] mem_q;
  logic [W-1:0]            dout_q;
  logic [AW:0]             ra_w;
  logic [AW-1:0]           ra;

  // modulo-DEPTH subtract, valid for non power-of-two depths too
  always_comb begin
    ra_w = {1'b0, wp_i} - {1'b0, dly_i};
    if (wp_i < dly_i) ra_w = ra_w + (AW+1)'(DEPTH);
    ra = ra_w[AW-1:0];
  end

  // reset clears the history so a short history reads as zeros, never stale data
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      mem_q  <= '0;
      dout_q <= '0;
    end else if (we_i) begin
      mem_q[wp_i] <= din_i;
      dout_q      <= (dly_i == '0) ? din_i : mem_q[ra];
    end
  end

  assign dout_o = dout_q;
endmodule

// File: rtl/beam_delay_bank.sv
// Multi-channel steering delay with a background-loaded direction table.
module beam_delay_bank import beam_pkg::*; #(
  parameter  int N_CH  = N_CH_DEF,
  parameter  int W     = W_DEF,
  parameter  int DEPTH = DEPTH_DEF,
  parameter  int N_DIR = N_DIR_DEF,
  localparam int AW    = $clog2(DEPTH),
  localparam int DIRW  = $clog2(N_DIR),
  localparam int CHW   = $clog2(N_CH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  input  logic [N_CH*W-1:0] pcm_in,
  input  logic [DIRW-1:0]   dir_sel,
  input  logic              cfg_we,
  input  logic [DIRW-1:0]   cfg_dir,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [AW:0]       cfg_delay,
  output logic              out_valid,
  output logic [N_CH*W-1:0] pcm_out,
  output logic [DIRW-1:0]   active_dir,
  output logic              busy
);
  reload_e                         state_q, state_d;
  logic [DIRW-1:0]                 dir_sel_q, tgt_q, tgt_d, active_q;
  logic [CHW-1:0]                  idx_q, idx_d;
  logic                            rd_en, swap;
  logic [N_DIR-1:0][N_CH-1:0][AW-1:0] tbl_q;
  logic [N_CH-1:0][AW-1:0]         shadow_q, live_q, dly_use;
  logic [AW-1:0]                   wp_q, cfg_sat;
  logic                            out_valid_q;

  assign cfg_sat = (cfg_delay > (AW+1)'(DEPTH-1)) ? AW'(DEPTH-1) : cfg_delay[AW-1:0];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= RL_IDLE;
      tgt_q     <= '0;
      idx_q     <= '0;
      dir_sel_q <= '0;
    end else begin
      state_q   <= state_d;
      tgt_q     <= tgt_d;
      idx_q     <= idx_d;
      dir_sel_q <= dir_sel;
    end
  end

  // A table write owns the single port, so LOAD skips its read that cycle.
  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    idx_d   = idx_q;
    rd_en   = 1'b0;
    swap    = 1'b0;
    unique case (state_q)
      RL_IDLE:
        if (dir_sel_q != active_q || (cfg_we && cfg_dir == active_q)) begin
          state_d = RL_LOAD;
          tgt_d   = dir_sel_q;
          idx_d   = '0;
        end
      RL_LOAD:
        if (dir_sel_q != tgt_q) begin
          tgt_d = dir_sel_q;
          idx_d = '0;
        end else if (!cfg_we) begin
          rd_en = 1'b1;
          if (idx_q == CHW'(N_CH-1)) state_d = RL_PEND;
          else                       idx_d   = idx_q + 1'b1;
        end
      RL_PEND:
        if (dir_sel_q != tgt_q) begin
          state_d = RL_LOAD;
          tgt_d   = dir_sel_q;
          idx_d   = '0;
        end else if (in_valid) begin
          swap    = 1'b1;
          state_d = RL_IDLE;
        end
      default: state_d = RL_IDLE;
    endcase
  end

  always_comb begin
    busy    = (state_q != RL_IDLE);
    dly_use = swap ? shadow_q : live_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbl_q       <= '0;
      shadow_q    <= '0;
      live_q      <= '0;
      active_q    <= '0;
      wp_q        <= '0;
      out_valid_q <= 1'b0;
    end else begin
      if (cfg_we) tbl_q[cfg_dir][cfg_ch] <= cfg_sat;
      if (rd_en)  shadow_q[idx_q] <= tbl_q[tgt_q][idx_q];
      if (swap) begin
        live_q   <= shadow_q;
        active_q <= tgt_q;
      end
      if (in_valid) wp_q <= (wp_q == AW'(DEPTH-1)) ? '0 : wp_q + 1'b1;
      out_valid_q <= in_valid;
    end
  end

  for (genvar c = 0; c < N_CH; c++) begin : g_ch
    delay_ring #(.W(W), .DEPTH(DEPTH)) u_ring (
      .clk    (clk),
      .rst    (rst),
      .wp_i   (wp_q),
      .we_i   (in_valid),
      .din_i  (pcm_in[c*W +: W]),
      .dly_i  (dly_use[c]),
      .dout_o (pcm_out[c*W +: W])
    );
  end

  assign out_valid  = out_valid_q;
  assign active_dir = active_q;
endmodule

// File: doc/beam_delay_bank.md
# beam_delay_bank

Parametrised multi-channel steering delay for the beamformer front end. It sits between the PCM decimators and the summing stage. Each of `N_CH` sample streams is delayed by a per-channel integer number of sample periods taken from a runtime-programmable direction table. A new direction is loaded in the background and switched in cleanly on a sample boundary, so output samples never mix delay sets.

## Interface
- `N_CH`, 8, number of microphone channels
- `W`, 19, PCM sample width (two's complement)
- `DEPTH`, 32, history depth per channel; legal delays are 0..`DEPTH`-1
- `N_DIR`, 32, number of direction table entries
- `clk` in 1: single clock
- `rst` in 1: reset. Asynchronous, active-low.
- `in_valid` in 1: one-cycle strobe; a new sample is present on every channel
- `pcm_in` in `N_CH*W`: channel c at bits [c*W +: W]
- `dir_sel` in `$clog2(N_DIR)`: requested direction
- `cfg_we` in 1: table write strobe
- `cfg_dir` in `$clog2(N_DIR)`: table write direction
- `cfg_ch` in `$clog2(N_CH)`: table write channel
- `cfg_delay` in `$clog2(DEPTH)+1`: delay value to write
- `out_valid` out 1: one-cycle strobe; delayed samples are valid
- `pcm_out` out `N_CH*W`: delayed samples, same packing as `pcm_in`
- `active_dir` out `$clog2(N_DIR)`: direction whose delays are live
- `busy` out 1: a reload is in progress or waiting to be swapped in

## Operation
- **History buffer.** Per channel, a circular buffer of `DEPTH` entries. All channels share one write pointer `wp`, which advances modulo `DEPTH` on each `in_valid`.
- **Output selection.** On `in_valid` with live delay d[c], channel c outputs the sample received d[c] strobes ago. d=0 is a bypass of the current input. Reads use address (`wp` - d) mod `DEPTH`.
- **History contents.** Before `DEPTH` samples have been written, history entries read as 0 and never as stale data.
- **Table storage.** The table holds `N_DIR` x `N_CH` delays, all 0 after reset. It is single-ported: one read or one write per cycle.
- **Saturation.** A `cfg_delay` greater than `DEPTH`-1 is stored as `DEPTH`-1.
- **Reload FSM states:** IDLE, LOAD, PEND.
  - IDLE -> LOAD when registered `dir_sel` != `active_dir`, or when `cfg_we` targets `active_dir`. Latch the target direction; channel index = 0.
  - LOAD reads one channel delay per cycle into a shadow register set, over `N_CH` read cycles, then moves to PEND.
  - A `cfg_we` in LOAD takes the table port. LOAD stalls that cycle and resumes at the same channel index.
  - If `dir_sel` changes during LOAD or PEND, the FSM returns to LOAD at channel 0 with the new target.
  - PEND: on the next `in_valid`, shadow -> live and `active_dir` <= target. That sample already uses the new delays. Then the FSM goes to IDLE.
- `busy` = (state != IDLE).
- **Live delays** change only in the PEND -> IDLE swap.
- **Reset (asynchronous, including mid-LOAD)** clears:
  - the history buffer, `wp`, the table, live and shadow delays;
  - `active_dir`=0, state=IDLE, `out_valid`=0, `pcm_out`=0.

## Timing
- Latency is 1 cycle: `in_valid` at cycle t gives `out_valid` and `pcm_out` at t+1. Both are registered.
- `pcm_out` holds its value between strobes.
- Reload time runs from a `dir_sel` change at cycle t:
  - `dir_sel` is registered at t+1;
  - LOAD runs from t+2 through t+1+`N_CH` plus stall cycles;
  - the swap happens at the first `in_valid` after that.
- Back-to-back `in_valid` (every cycle) must be supported.
- `in_valid` and a table write in the same cycle do not interact.
- A swap in the same cycle as `in_valid` is defined: new delays apply to that sample.

## Structure
- Shared package `beam_pkg` holds:
  - `N_CH_DEF`, `W_DEF`, `DEPTH_DEF`, `N_DIR_DEF`;
  - the reload state enum;
  - a `delay_t` typedef.
- Sub-module `delay_ring`: one channel's circular buffer. Inputs are `wp`, the write strobe, the sample and the delay; output is the registered delayed sample. It is instantiated `N_CH` times.
- The table, FSM and shadow/live registers live in the top module.

## Test plan
- **Reset state.** Release reset, feed 40 strobes of ramp 1,2,3,... on all channels.
  - `pcm_out` equals the input delayed by 1 cycle.
  - `active_dir`=0 and `busy`=0.
- **Basic load.** Write dir 3 = {0,2,4,6,8,10,12,14}, set `dir_sel`=3, then feed the ramp.
  - `busy` is high for at least 9 cycles, then `active_dir`=3.
  - Channel 7 outputs n-14 after warm-up and 0 before it.
- **Saturation.** Write `cfg_delay`=40 with `DEPTH`=32 and select that direction.
  - The channel outputs the sample 31 strobes old.
- **Restart mid-load.** Change `dir_sel` 3 -> 5 during LOAD, and issue `cfg_we` to an unrelated direction in the same window.
  - LOAD restarts at channel 0 and stalls one cycle for the write.
  - The final live delays equal dir 5 exactly; no mix of 3 and 5.
- **Write to active direction.** Write a new delay to `active_dir`.
  - A reload triggers automatically, and the new delay takes effect at the swap strobe, not before.
- **Reset mid-LOAD.** Assert `rst` low during LOAD with continuous `in_valid`.
  - All outputs are 0, the FSM is in IDLE and the table is cleared.
  - The history reads 0 after reset is released.
